// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// Pure declarations; no latency or flow-control behaviour of its own.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Bits needed to encode n distinct values; callers always pass n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request scanning upward from ptr, wrapping.
// Purely combinational, zero latency; no flow control.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    // Scan from the farthest offset back to ptr so the nearest hit is written last.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin owner of a shared WIDTH-bit register: grant visible one edge after req, first write one edge later.
// Tenures end on request drop or after MAX_HOLD writes; non-owners simply wait, with zero-bubble handoff.
module rr_reg_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [clog2(NREQ)-1:0]   owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         Q
);

    localparam int PW = clog2(NREQ);
    localparam int CW = clog2(MAX_HOLD + 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  q_q,     q_d;

    logic [PW-1:0]     owner_inc;
    logic [PW-1:0]     pick_ptr;
    logic [PW-1:0]     pick_idx;
    logic              pick_vld;
    logic              own_req;

    assign owner_inc = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    assign own_req   = req[owner_q];

    // On release the search starts just past the outgoing owner, which is also the new ptr.
    assign pick_ptr  = (state_q == OWN) ? owner_inc : ptr_q;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWN;
                    gnt_d   = NREQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = CW'(1);
                end
            end
            OWN: begin
                if (own_req) begin
                    q_d = wdata[owner_q*WIDTH +: WIDTH];
                end
                if (!own_req || (cnt_q == CW'(MAX_HOLD))) begin
                    ptr_d = owner_inc;
                    if (pick_vld) begin
                        gnt_d   = NREQ'(1) << pick_idx;
                        owner_d = pick_idx;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == OWN);
    assign Q     = q_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q));
            assert (cnt_q <= CW'(MAX_HOLD));
        end
    end
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed, table-driven bench for rr_reg_arbiter (NREQ=4, WIDTH=8, MAX_HOLD=4).
module tb_rr_reg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  Q;

    always #5 clk = ~clk;

    rr_reg_arbiter #(
        .NREQ     (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .Q     (Q)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        busy;
        logic [7:0]  q;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] r, input logic [31:0] w, input logic [3:0] g,
                                input logic [1:0] o, input logic b, input logic [7:0] q);
        vec_t v;
        v.req = r; v.wdata = w; v.gnt = g; v.owner = o; v.busy = b; v.q = q;
        tbl.push_back(v);
    endfunction

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic [7:0] q);
        check({tag, ".gnt"},   32'(gnt),   32'(g));
        check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".Q"},     32'(Q),     32'(q));
    endtask

    // Each row: drive inputs, take one rising edge, compare 1 time unit later.
    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            req   = tbl[i].req;
            wdata = tbl[i].wdata;
            @(posedge clk);
            #1;
            check_all($sformatf("%s[%0d]", tag, i), tbl[i].gnt, tbl[i].owner, tbl[i].busy, tbl[i].q);
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] w_iso;
        req   = '0;
        wdata = '0;

        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Single short request, then lone requester hitting the hold limit.
        add(4'b0001, 32'h000000A5, 4'b0001, 2'd0, 1'b1, 8'h00);
        add(4'b0001, 32'h000000A5, 4'b0001, 2'd0, 1'b1, 8'hA5);
        add(4'b0000, 32'h000000A5, 4'b0000, 2'd0, 1'b0, 8'hA5);
        add(4'b0000, 32'h000000A5, 4'b0000, 2'd0, 1'b0, 8'hA5);
        add(4'b0001, 32'h00000001, 4'b0001, 2'd0, 1'b1, 8'hA5);
        add(4'b0001, 32'h00000001, 4'b0001, 2'd0, 1'b1, 8'h01);
        add(4'b0001, 32'h00000002, 4'b0001, 2'd0, 1'b1, 8'h02);
        add(4'b0001, 32'h00000003, 4'b0001, 2'd0, 1'b1, 8'h03);
        add(4'b0001, 32'h00000004, 4'b0001, 2'd0, 1'b1, 8'h04);
        add(4'b0001, 32'h00000005, 4'b0001, 2'd0, 1'b1, 8'h05);
        add(4'b0000, 32'h00000006, 4'b0000, 2'd0, 1'b0, 8'h05);
        run_table("short_hold");

        // Reset asserted mid-tenure must clear outputs without waiting for a clock edge.
        req   = 4'b0100;
        wdata = 32'h003C0000;
        @(posedge clk); #1;
        check_all("mid_rst.grant", 4'b0100, 2'd2, 1'b1, 8'h05);
        @(posedge clk); #1;
        check_all("mid_rst.write", 4'b0100, 2'd2, 1'b1, 8'h3C);
        #2 rst = 1'b1;
        #1;
        check_all("mid_rst.async", 4'b0000, 2'd0, 1'b0, 8'h00);
        @(posedge clk); #1;
        check_all("mid_rst.held", 4'b0000, 2'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_all("mid_rst.regrant", 4'b0100, 2'd2, 1'b1, 8'h00);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);

        // Full contention, early-drop handoff with wrap, then non-owner isolation.
        w     = 32'h44332211;
        w_iso = 32'hFF000011;
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h00);
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1111, w, 4'b0010, 2'd1, 1'b1, 8'h11);
        add(4'b1111, w, 4'b0010, 2'd1, 1'b1, 8'h22);
        add(4'b1111, w, 4'b0010, 2'd1, 1'b1, 8'h22);
        add(4'b1111, w, 4'b0010, 2'd1, 1'b1, 8'h22);
        add(4'b1111, w, 4'b0100, 2'd2, 1'b1, 8'h22);
        add(4'b1111, w, 4'b0100, 2'd2, 1'b1, 8'h33);
        add(4'b1111, w, 4'b0100, 2'd2, 1'b1, 8'h33);
        add(4'b1111, w, 4'b0100, 2'd2, 1'b1, 8'h33);
        add(4'b1111, w, 4'b1000, 2'd3, 1'b1, 8'h33);
        add(4'b1111, w, 4'b1000, 2'd3, 1'b1, 8'h44);
        add(4'b1111, w, 4'b1000, 2'd3, 1'b1, 8'h44);
        add(4'b1111, w, 4'b1000, 2'd3, 1'b1, 8'h44);
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h44);
        add(4'b1111, w, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1110, w, 4'b0010, 2'd1, 1'b1, 8'h11);
        add(4'b1110, w, 4'b0010, 2'd1, 1'b1, 8'h22);
        add(4'b1101, w, 4'b0100, 2'd2, 1'b1, 8'h22);
        add(4'b1001, w, 4'b1000, 2'd3, 1'b1, 8'h22);
        add(4'b1001, w, 4'b1000, 2'd3, 1'b1, 8'h44);
        add(4'b0001, w, 4'b0001, 2'd0, 1'b1, 8'h44);
        add(4'b1001, w_iso, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1001, w_iso, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1001, w_iso, 4'b0001, 2'd0, 1'b1, 8'h11);
        add(4'b1001, w_iso, 4'b1000, 2'd3, 1'b1, 8'h11);
        add(4'b1001, w_iso, 4'b1000, 2'd3, 1'b1, 8'hFF);
        add(4'b0000, w_iso, 4'b0000, 2'd0, 1'b0, 8'hFF);
        run_table("contend");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register (the D/Q flop bank) between NREQ requesters.
- Grants one requester at a time for a bounded tenure. While granted, that requester's data is loaded into the register every cycle it keeps its request high.
- Sits in front of the shared register in the fsm_verilog design. It is the only writer of Q.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data / register width
MAX_HOLD, 4, maximum write cycles per tenure (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester, level-sensitive
wdata  input  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant (all-zero when idle)
owner  output  clog2(NREQ)  index of current grantee (0 when idle)
busy  output  1  high while a tenure is active (gnt != 0)
Q  output  WIDTH  shared register contents

Behaviour:
- Interface: single clock clk. Reset rst is asynchronous and active-high.
- Reset, asynchronous, effective immediately and at any time including mid-tenure:
  - state=IDLE; gnt=0, owner=0, busy=0, Q=0.
  - Rotation pointer ptr=0; hold counter cnt=0.
  - First arbitration happens at the first clk edge after rst deasserts.
- Arbitration function pick(req, ptr): the first i with req[i]=1, scanning ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1. Result is none if req=0.
- State IDLE, at each posedge:
  - If pick finds winner w: gnt<=onehot(w), owner<=w, cnt<=1, state<=OWN.
  - Otherwise stay in IDLE with outputs unchanged.
  - No write to Q occurs in IDLE.
- State OWN (owner i), at each posedge:
  - Write: if req[i]=1 then Q<=wdata slice i. Otherwise Q holds.
  - Release condition: req[i]=0, or cnt==MAX_HOLD. The write above still happens in the cnt==MAX_HOLD cycle.
  - No release: cnt<=cnt+1, and gnt/owner stay the same.
  - On release:
    - ptr<=(i+1) mod NREQ.
    - Re-arbitrate in the same edge with pick(req, (i+1) mod NREQ) on the current req. A requester whose hold just expired and still requests is therefore lowest priority.
    - Winner w: gnt<=onehot(w), owner<=w, cnt<=1, stay in OWN. This is a zero-bubble handoff.
    - No winner: gnt<=0, owner<=0, cnt<=0, state<=IDLE.
- Latency:
  - req rises before edge E → gnt valid after E.
  - First Q update at edge E+1, visible after E+1.
- Each tenure performs at most MAX_HOLD writes.
- Pointer wrap: owner NREQ-1 releases → ptr=0.
- Lone requester with hold expired: it is re-granted at the release edge with no idle cycle, and cnt restarts at 1.
- Requests from non-owners during a tenure are ignored until release. Non-owner wdata never reaches Q.
- busy = (state==OWN), driven from the registered state. gnt is always one-hot or zero.
- cnt width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.

Decomposition:
- Shared package rr_arb_pkg:
  - state encoding constants IDLE=1'b0, OWN=1'b1;
  - clog2 constant function.
- Sub-module rr_pick: purely combinational rotating priority encoder.
  - Inputs: req, ptr.
  - Outputs: valid, idx.
  - Instantiated once in rr_reg_arbiter.
- The Q register, FSM, ptr and cnt stay in the top module.

Test Plan:
- Reset mid-tenure: owner 2 active with Q=8'h3C, pulse rst between edges → gnt=0, busy=0, Q=0 immediately; after release, req=0100 → gnt=0100 one edge later.
- Single short request: req=0001, wdata0=8'hA5, held 2 edges then dropped → after edge1 gnt=0001; after edge2 Q=A5; after drop edge gnt=0, busy=0; Q stays A5.
- Hold limit, lone requester: req=0001 constant, wdata0 = 1, 2, 3, ... per cycle, MAX_HOLD=4 → Q updates on 4 consecutive edges, then regrant 0001 with gnt never dropping; cnt restarts at 1.
- Full contention: req=1111 constant → grant sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, no bubble cycles.
- Early-drop handoff: owner 1 drops req at cnt=2 while req=1101 → same edge gnt=0100 (index 2); next release → 1000; then wrap to 0001.
- Non-owner isolation: owner 0 writing 8'h11 while req[3]=1 with wdata3=8'hFF → Q never equals FF until gnt=1000 and one further edge.
